// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with prefetch FIFO for the LoongArch core.
// Issues sequential inst SRAM reads, tracks them through a SRAM_LAT-deep
// in-flight pipe and queues returned {inst, pc} pairs for ID.
// Optional feature macro: INST_ADE_CHECK_EN (misaligned-redirect ADE entry + HALT).
module if_prefetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       SRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c00_0000)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    br_taken,
  input  logic [ADDR_W-1:0]       br_target,
  output logic                    inst_sram_en,
  output logic                    inst_sram_we,
  output logic [ADDR_W-1:0]       inst_sram_addr,
  output logic [DATA_W-1:0]       inst_sram_wdata,
  input  logic [DATA_W-1:0]       inst_sram_rdata,
  output logic                    fs_to_ds_valid,
  output logic [DATA_W-1:0]       fs_to_ds_inst,
  output logic [ADDR_W-1:0]       fs_to_ds_pc,
  input  logic                    ds_allowin,
`ifdef INST_ADE_CHECK_EN
  output logic                    fs_to_ds_ade,
`endif
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LAST  = SRAM_LAT - 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic              infl_vld [SRAM_LAT];
  logic [ADDR_W-1:0] infl_pc  [SRAM_LAT];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inflight;
  logic [ADDR_W-1:0] tgt_pc;
  logic              fifo_empty;
  logic              arrive;
  logic              head_avail;
  logic              head_valid;
  logic              pop;
  logic              pop_fifo;
  logic              push;
  logic              issue;
  logic              halt;

`ifdef INST_ADE_CHECK_EN
  typedef enum logic {ST_RUN, ST_HALT} state_e;
  state_e state;
  state_e state_nxt;
  logic   tgt_misalign;
  logic   mem_ade [DEPTH];

  assign tgt_misalign = (br_target[1:0] != 2'b00);
  assign tgt_pc       = br_target;
  assign halt         = (state == ST_HALT);

  // RUN/HALT state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // HALT is entered by a misaligned redirect and left by any later redirect
  always_comb begin
    state_nxt = state;
    if (br_taken) state_nxt = tgt_misalign ? ST_HALT : ST_RUN;
  end
`else
  assign tgt_pc = br_target & ~ADDR_W'(3);
  assign halt   = 1'b0;
`endif

  // Number of requests still travelling through the SRAM pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) inflight = inflight + CNT_W'(infl_vld[i]);
  end

  // Arriving data bypasses an empty FIFO so a request at t is visible at t+SRAM_LAT
  assign arrive     = infl_vld[LAST];
  assign fifo_empty = (count == '0);
  assign head_avail = !fifo_empty || arrive;
  assign head_valid = !reset && !br_taken && head_avail;
  assign pop        = head_valid && ds_allowin;
  assign pop_fifo   = pop && !fifo_empty;
  assign push       = arrive && !(pop && fifo_empty);
  assign issue      = !reset && !br_taken && !halt &&
                      ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));

  assign inst_sram_en    = issue;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = reset ? '0 : fetch_pc;
  assign fifo_count      = reset ? '0 : count;
  assign fs_to_ds_valid  = head_valid;

  // Head selection: FIFO entry if present, else the arriving SRAM beat
  always_comb begin
    fs_to_ds_inst = '0;
    fs_to_ds_pc   = '0;
`ifdef INST_ADE_CHECK_EN
    fs_to_ds_ade  = 1'b0;
`endif
    if (!reset && head_avail) begin
      if (fifo_empty) begin
        fs_to_ds_inst = inst_sram_rdata;
        fs_to_ds_pc   = infl_pc[LAST];
      end else begin
        fs_to_ds_inst = mem_inst[rd_ptr];
        fs_to_ds_pc   = mem_pc[rd_ptr];
`ifdef INST_ADE_CHECK_EN
        fs_to_ds_ade  = mem_ade[rd_ptr];
`endif
      end
    end
  end

  // Control state: fetch PC, in-flight valids, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < SRAM_LAT; i++) infl_vld[i] <= 1'b0;
    end else if (br_taken) begin
      fetch_pc <= tgt_pc;
      rd_ptr   <= '0;
      for (int i = 0; i < SRAM_LAT; i++) infl_vld[i] <= 1'b0;
`ifdef INST_ADE_CHECK_EN
      if (tgt_misalign) begin
        wr_ptr <= PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
`else
      wr_ptr   <= '0;
      count    <= '0;
`endif
    end else begin
      infl_vld[0] <= issue;
      for (int i = 1; i < SRAM_LAT; i++) infl_vld[i] <= infl_vld[i-1];
      if (issue)    fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)     wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop_fifo) rd_ptr   <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  // In-flight PC pipe, aligned with the SRAM read latency
  always_ff @(posedge clk) begin
    infl_pc[0] <= fetch_pc;
    for (int i = 1; i < SRAM_LAT; i++) infl_pc[i] <= infl_pc[i-1];
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (!reset && br_taken) begin
`ifdef INST_ADE_CHECK_EN
      if (tgt_misalign) begin
        mem_inst[0] <= '0;
        mem_pc[0]   <= br_target;
        mem_ade[0]  <= 1'b1;
      end
`endif
    end else if (!reset && push) begin
      mem_inst[wr_ptr] <= inst_sram_rdata;
      mem_pc[wr_ptr]   <= infl_pc[LAST];
`ifdef INST_ADE_CHECK_EN
      mem_ade[wr_ptr]  <= 1'b0;
`endif
    end
  end

endmodule
